reg_display_scan: RTL and testbench

- Downstream consumer of the 8x4 register bank's two read ports.
- Drives the bank's read addresses, either passed through from the board switches or auto-swept.
- Snapshots the returned data once per display frame and shows read address and data for ports A and B on a 4-digit multiplexed 7-segment display.
- Sits between the register bank and the board's anode/segment pins.

---
 rtl/reg_display_scan_pkg.sv | 47 ++++
 rtl/reg_display_scan_hex_to_seg7.sv | 16 +
 rtl/reg_display_scan.sv | 172 +++++++++++++++++
 tb/tb_reg_display_scan.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_display_scan_pkg.sv
// ---------------------------------------------------------------------------
// reg_display_scan_pkg
// Shared definitions for the register-bank display scanner:
//   NUM_DIGITS / DIGIT_W - digit count of the multiplexed display and index width
//   scanState_t          - address-source FSM states (MANUAL / SCAN)
//   HEX_SEG              - active-low {g,f,e,d,c,b,a} patterns for hex 0..F
//   SEG_OFF / AN_OFF     - active-low "everything dark" values
//   digitEnable()        - active-low one-cold anode pattern for a digit index
// ---------------------------------------------------------------------------
package reg_display_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } scanState_t;

    // Index 0 is the rightmost element of the concatenation.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    localparam logic [6:0]            SEG_OFF = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = '1;

    function automatic logic [NUM_DIGITS-1:0] digitEnable(input logic [DIGIT_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/reg_display_scan_hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex digit to active-low 7-segment decode.
//   digit : in  4  hex value 0..F
//   segN  : out 7  active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex_to_seg7
    import reg_display_scan_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] segN
);

    assign segN = HEX_SEG[digit];

endmodule

// File: rtl/reg_display_scan.sv
// ---------------------------------------------------------------------------
// reg_display_scan
// Drives the read addresses of an 8x4 register bank (manual switches or an
// automatic sweep), snapshots both read ports once per display frame and shows
// {datA, addrA, datB, addrB} on a 4-digit multiplexed 7-segment display.
//
// Ports:
//   clk        in   1         system clock, rising edge
//   rst        in   1         synchronous, active-low reset
//   sw_addrRa  in   BIT_ADDR  manual read address, port A
//   sw_addrRb  in   BIT_ADDR  manual read address, port B
//   scan_en    in   1         1 = auto-sweep, 0 = manual
//   addrRa     out  BIT_ADDR  registered read address, port A
//   addrRb     out  BIT_ADDR  registered read address, port B
//   datRa      in   BIT_DATO  bank read data A (combinational from addrRa)
//   datRb      in   BIT_DATO  bank read data B (combinational from addrRb)
//   an         out  4         digit enables (active-low by default)
//   seg        out  7         segments {g,f,e,d,c,b,a} (active-low by default)
//
// Build option: define DISP_ACTIVE_HIGH_EN to drive an/seg active-high
// (dark = all zeros). Timing and FSM behaviour do not change.
// ---------------------------------------------------------------------------
module reg_display_scan
    import reg_display_scan_pkg::*;
#(
    parameter int BIT_ADDR     = 3,
    parameter int BIT_DATO     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int DWELL_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIT_ADDR-1:0]   sw_addrRa,
    input  logic [BIT_ADDR-1:0]   sw_addrRb,
    input  logic                  scan_en,
    output logic [BIT_ADDR-1:0]   addrRa,
    output logic [BIT_ADDR-1:0]   addrRb,
    input  logic [BIT_DATO-1:0]   datRa,
    input  logic [BIT_DATO-1:0]   datRb,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg
);

    localparam int REF_W   = $clog2(REFRESH_DIV);
    localparam int FRAME_W = $clog2(DWELL_FRAMES + 1);

`ifdef DISP_ACTIVE_HIGH_EN
    localparam logic INVERT = 1'b1;
`else
    localparam logic INVERT = 1'b0;
`endif

    logic [REF_W-1:0]    refCnt;
    logic [DIGIT_W-1:0]  digitIdx;
    logic [FRAME_W-1:0]  frameCnt;
    scanState_t          state;

    logic [BIT_DATO-1:0] holdDa;
    logic [BIT_DATO-1:0] holdDb;
    logic [BIT_ADDR-1:0] holdAa;
    logic [BIT_ADDR-1:0] holdAb;

    logic [3:0]          digitVal;
    logic [6:0]          segDecoded;

    logic refWrap;
    logic frameEnd;
    logic dwellDone;

    assign refWrap   = (refCnt == REF_W'(REFRESH_DIV - 1));
    assign frameEnd  = refWrap && (digitIdx == DIGIT_W'(NUM_DIGITS - 1));
    // frameCnt has already counted DWELL_FRAMES-1 boundaries; this boundary
    // completes the dwell.
    assign dwellDone = frameEnd && (frameCnt == FRAME_W'(DWELL_FRAMES - 1));

    // ---- refresh timebase and digit index ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            refCnt   <= '0;
            digitIdx <= '0;
        end else if (refWrap) begin
            refCnt   <= '0;
            digitIdx <= digitIdx + DIGIT_W'(1);
        end else begin
            refCnt   <= refCnt + REF_W'(1);
        end
    end

    // ---- frame snapshot: display content only changes at frame boundaries ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            holdDa <= '0;
            holdAa <= '0;
            holdDb <= '0;
            holdAb <= '0;
        end else if (frameEnd) begin
            holdDa <= datRa;
            holdAa <= addrRa;
            holdDb <= datRb;
            holdAb <= addrRb;
        end
    end

    // ---- address-source FSM with frame counter ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= MANUAL;
            addrRa   <= '0;
            addrRb   <= '0;
            frameCnt <= '0;
        end else begin
            case (state)
                MANUAL: begin
                    if (scan_en) begin
                        state    <= SCAN;
                        addrRa   <= '0;
                        addrRb   <= BIT_ADDR'(1);
                        frameCnt <= '0;
                    end else begin
                        addrRa <= sw_addrRa;
                        addrRb <= sw_addrRb;
                        if (frameEnd) frameCnt <= frameCnt + FRAME_W'(1);
                    end
                end
                SCAN: begin
                    // Leaving SCAN takes priority over a coincident dwell step.
                    if (!scan_en) begin
                        state  <= MANUAL;
                        addrRa <= sw_addrRa;
                        addrRb <= sw_addrRb;
                        if (frameEnd) frameCnt <= frameCnt + FRAME_W'(1);
                    end else if (dwellDone) begin
                        addrRa   <= addrRa + BIT_ADDR'(1);
                        addrRb   <= addrRa + BIT_ADDR'(2);
                        frameCnt <= '0;
                    end else if (frameEnd) begin
                        frameCnt <= frameCnt + FRAME_W'(1);
                    end
                end
                default: state <= MANUAL;
            endcase
        end
    end

    // ---- digit select and decode ----
    always_comb begin
        digitVal = 4'(holdDa);
        case (digitIdx)
            DIGIT_W'(0): digitVal = 4'(holdDa);
            DIGIT_W'(1): digitVal = 4'(holdAa);
            DIGIT_W'(2): digitVal = 4'(holdDb);
            default:     digitVal = 4'(holdAb);
        endcase
    end

    hex_to_seg7 u_hexToSeg7 (
        .digit (digitVal),
        .segN  (segDecoded)
    );

    // ---- registered display outputs, polarity applied last ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            an  <= AN_OFF ^ {NUM_DIGITS{INVERT}};
            seg <= SEG_OFF ^ {7{INVERT}};
        end else begin
            an  <= digitEnable(digitIdx) ^ {NUM_DIGITS{INVERT}};
            seg <= segDecoded ^ {7{INVERT}};
        end
    end

endmodule

// File: tb/tb_reg_display_scan.sv
// ---------------------------------------------------------------------------
// tb_reg_display_scan
// Directed bench for reg_display_scan with REFRESH_DIV=4, DWELL_FRAMES=2
// (16-cycle frames, dwell step every 32 cycles). Edge numbers below count
// rising clock edges after reset release. Expected display values are written
// active-low and converted when DISP_ACTIVE_HIGH_EN is defined.
// ---------------------------------------------------------------------------
module tb_reg_display_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sw_addrRa;
    logic [2:0] sw_addrRb;
    logic       scan_en;
    logic [2:0] addrRa;
    logic [2:0] addrRb;
    logic [3:0] datRa;
    logic [3:0] datRb;
    logic [3:0] an;
    logic [6:0] seg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    reg_display_scan #(
        .BIT_ADDR     (3),
        .BIT_DATO     (4),
        .REFRESH_DIV  (4),
        .DWELL_FRAMES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_addrRa (sw_addrRa),
        .sw_addrRb (sw_addrRb),
        .scan_en   (scan_en),
        .addrRa    (addrRa),
        .addrRb    (addrRb),
        .datRa     (datRa),
        .datRb     (datRb),
        .an        (an),
        .seg       (seg)
    );

    function automatic logic [3:0] polAn(input logic [3:0] x);
`ifdef DISP_ACTIVE_HIGH_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    function automatic logic [6:0] polSeg(input logic [6:0] x);
`ifdef DISP_ACTIVE_HIGH_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tickTo(input int n);
        while (cyc < n) tick();
    endtask

    // Scan steps every 32 edges starting at edge 112.
    int         stepEdge [7] = '{112, 144, 176, 208, 240, 272, 304};
    logic [2:0] stepA    [7] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [2:0] stepB    [7] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

    initial begin
        rst       = 1'b0;
        scan_en   = 1'b0;
        sw_addrRa = 3'd0;
        sw_addrRb = 3'd0;
        datRa     = 4'h0;
        datRb     = 4'h0;

        // Reset held for 3 cycles
        repeat (3) tick();
        checkVal("rst_an",    an,     polAn(4'b1111));
        checkVal("rst_seg",   seg,    polSeg(7'b1111111));
        checkVal("rst_addrA", addrRa, 3'd0);
        checkVal("rst_addrB", addrRb, 3'd0);

        rst = 1'b1;
        cyc = 0;

        // First lit digit and refresh cadence
        tickTo(1);
        checkVal("first_an",  an,  polAn(4'b1110));
        checkVal("first_seg", seg, polSeg(7'b1000000));
        tickTo(4);
        checkVal("an_e4",  an, polAn(4'b1110));
        tickTo(5);
        checkVal("an_e5",  an, polAn(4'b1101));
        tickTo(16);
        checkVal("an_e16", an, polAn(4'b0111));
        tickTo(17);
        checkVal("an_e17", an, polAn(4'b1110));

        // Manual addresses, 1-cycle latency
        sw_addrRa = 3'd5;
        sw_addrRb = 3'd3;
        datRa     = 4'hA;
        datRb     = 4'h7;
        checkVal("man_lat_A", addrRa, 3'd0);
        tickTo(18);
        checkVal("man_addrA", addrRa, 3'd5);
        checkVal("man_addrB", addrRb, 3'd3);
        checkVal("old_hold_seg", seg, polSeg(7'b1000000));

        // Snapshot taken at edge 32
        tickTo(33);
        checkVal("d0_an",  an,  polAn(4'b1110));
        checkVal("d0_seg", seg, polSeg(7'b0001000));
        datRa = 4'hC;
        tickTo(35);
        checkVal("d0_noTear", seg, polSeg(7'b0001000));
        tickTo(37);
        checkVal("d1_an",  an,  polAn(4'b1101));
        checkVal("d1_seg", seg, polSeg(7'b0010010));
        tickTo(41);
        checkVal("d2_seg", seg, polSeg(7'b1111000));
        tickTo(45);
        checkVal("d3_an",  an,  polAn(4'b0111));
        checkVal("d3_seg", seg, polSeg(7'b0110000));
        tickTo(49);
        checkVal("d0_newC", seg, polSeg(7'b1000110));

        // Auto-sweep
        scan_en = 1'b1;
        tickTo(50);
        checkVal("scan0_A", addrRa, 3'd0);
        checkVal("scan0_B", addrRb, 3'd1);
        tickTo(79);
        checkVal("dwell_A", addrRa, 3'd0);
        checkVal("dwell_B", addrRb, 3'd1);
        tickTo(80);
        checkVal("scan1_A", addrRa, 3'd1);
        checkVal("scan1_B", addrRb, 3'd2);
        for (int i = 0; i < 7; i++) begin
            tickTo(stepEdge[i]);
            checkVal($sformatf("step%0d_A", i + 2), addrRa, stepA[i]);
            checkVal($sformatf("step%0d_B", i + 2), addrRb, stepB[i]);
        end

        // scan_en drops on a dwell-expiry edge (336): MANUAL wins
        tickTo(335);
        checkVal("preExp_A", addrRa, 3'd0);
        scan_en   = 1'b0;
        sw_addrRa = 3'd2;
        sw_addrRb = 3'd6;
        tickTo(336);
        checkVal("exp_man_A", addrRa, 3'd2);
        checkVal("exp_man_B", addrRb, 3'd6);
        sw_addrRa = 3'd4;
        sw_addrRb = 3'd1;
        tickTo(337);
        checkVal("man2_A", addrRa, 3'd4);
        checkVal("man2_B", addrRb, 3'd1);

        // Reset while scanning with digit2 lit
        scan_en = 1'b1;
        tickTo(338);
        checkVal("rescan_A", addrRa, 3'd0);
        checkVal("rescan_B", addrRb, 3'd1);
        tickTo(345);
        checkVal("mid_an",  an,  polAn(4'b1011));
        checkVal("mid_seg", seg, polSeg(7'b1111000));
        rst = 1'b0;
        tickTo(346);
        checkVal("rst2_an",    an,     polAn(4'b1111));
        checkVal("rst2_seg",   seg,    polSeg(7'b1111111));
        checkVal("rst2_addrA", addrRa, 3'd0);
        checkVal("rst2_addrB", addrRb, 3'd0);
        // Back in MANUAL with scan_en high: next edge enters SCAN at 0/1
        rst = 1'b1;
        tickTo(347);
        checkVal("post_A",   addrRa, 3'd0);
        checkVal("post_B",   addrRb, 3'd1);
        checkVal("post_an",  an,     polAn(4'b1110));
        checkVal("post_seg", seg,    polSeg(7'b1000000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
